mantenimiento_arbiter: RTL and testbench
========================================

Name: mantenimiento_arbiter

Overview:
- Round-robin arbiter that shares the single mantenimiento_fsm maintenance resource among N requesting units.
- Grants one requester at a time and drives the FSM's `mantenimiento` input. Treats the FSM's `terminado` as completion, with a timeout watchdog.
- Sits directly in front of mantenimiento_fsm: `mant_on` connects to `mantenimiento`, `mant_terminado` connects from `terminado`.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_CYCLES, 200, SERVICE cycles allowed before timeout error (>=2).
- COOLDOWN_CYCLES, 3, idle cycles between consecutive services (0 = none).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on clk edge).
- req  input  N  per-requester maintenance request, level.
- mant_terminado  input  1  completion from mantenimiento_fsm (`terminado`).
- clear_error  input  1  single-cycle pulse, leaves ERROR.
- mant_on  output  1  drives mantenimiento_fsm `mantenimiento`.
- grant  output  N  one-hot current owner, 0 when none.
- done  output  N  one-cycle pulse on owner's bit at completion.
- busy  output  1  1 in any state except IDLE.
- error  output  1  1 while in ERROR.
- error_id  output  3  index of requester that timed out; holds until next error.
- service_count  output  8  completed services, saturating at 255.

Behaviour:
- Reset (reset==0 at edge):
  - Outputs: state=IDLE, mant_on=0, grant=0, done=0, busy=0, error=0, error_id=0, service_count=0.
  - Internal: rr_ptr=0, timer=0.
  - Reset mid-service drops mant_on on the following edge. No done pulse, no count.
- All outputs are registered.
- States: IDLE, GRANT, SERVICE, DONE, COOLDOWN, ERROR.
- IDLE:
  - If req!=0, select the first set bit scanning from rr_ptr upward with wrap.
  - Load grant with that one-hot; go to GRANT.
  - If req==0, stay in IDLE.
- GRANT (1 cycle):
  - grant valid, mant_on=0, timer=0.
  - Go to SERVICE.
- SERVICE:
  - mant_on=1; timer increments every cycle in SERVICE.
  - If mant_terminado==1, go to DONE.
  - Else if timer==MAX_CYCLES-1, go to ERROR.
  - terminado has priority over timeout in the same cycle.
  - Deasserting req during GRANT/SERVICE does not abort; the service runs to completion or timeout.
- DONE (1 cycle):
  - mant_on=0, grant held.
  - done[owner]=1 for this cycle only.
  - service_count increments, saturating at 255.
  - rr_ptr = owner+1 mod N.
  - Go to COOLDOWN, or straight to IDLE if COOLDOWN_CYCLES==0.
- COOLDOWN:
  - grant=0, mant_on=0, busy=1.
  - After exactly COOLDOWN_CYCLES cycles, go to IDLE.
  - req is ignored.
- ERROR:
  - mant_on=0, grant=0, error=1, error_id=owner index (latched on entry).
  - service_count unchanged.
  - req is ignored.
  - On clear_error==1: rr_ptr = error_id+1 mod N, go to IDLE. error drops on that edge.
- Latency:
  - req rising in IDLE to grant visible: 1 cycle.
  - grant to mant_on: 1 cycle.
  - mant_terminado high to done pulse: 1 cycle.
- Fairness: with all requests continuously asserted, requesters are served in order 0,1,..,N-1,0.
- Invariants:
  - grant is zero or one-hot.
  - mant_on=1 only in SERVICE.
  - done!=0 only in DONE.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with req=4'b1111 and mant_terminado=1 -> all outputs 0, state IDLE. Release reset -> grant=4'b0001 after 1 cycle, mant_on=1 after 2 cycles.
- Single service: req=4'b0100, terminado pulsed 5 cycles after mant_on rises -> grant=4'b0100, mant_on high 6 cycles, done=4'b0100 for 1 cycle, service_count=1, busy low 3 cycles after DONE.
- Round-robin: req=4'b1111 held, each service completed after 3 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with COOLDOWN of 3 cycles between each; service_count=5.
- Timeout: MAX_CYCLES=20, req=4'b0010, terminado held 0 -> mant_on high exactly 20 cycles, then error=1, error_id=1, grant=0, count unchanged.
  - Apply clear_error with req=4'b0011 -> next grant=4'b0001 (rr_ptr=2 wraps to bit 0).
- Boundary: terminado asserted on timer==MAX_CYCLES-1 -> DONE taken, no error, count increments.
- Reset mid-service: reset=0 on the 10th SERVICE cycle -> next edge mant_on=0, grant=0, service_count=0. After release, rr_ptr=0 and lowest set req is granted.

Source files
------------

// File: rtl/mantenimiento_arbiter.sv
// Round-robin arbiter in front of mantenimiento_fsm: grants one requester at a time,
// drives mant_on during service and watches for completion or timeout.
module mantenimiento_arbiter #(
    parameter int N               = 4,
    parameter int MAX_CYCLES      = 200,
    parameter int COOLDOWN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         mant_terminado,
    input  logic         clear_error,
    output logic         mant_on,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic         busy,
    output logic         error,
    output logic [2:0]   error_id,
    output logic [7:0]   service_count
);
    localparam int CNT_MAX = (MAX_CYCLES > COOLDOWN_CYCLES) ? MAX_CYCLES : COOLDOWN_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MAX_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LAST    = TW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SERVICE,
        S_DONE,
        S_COOLDOWN,
        S_ERROR
    } state_t;

    state_t         state, state_n;
    logic [TW-1:0]  timer, timer_n;
    logic [2:0]     rr_ptr, rr_ptr_n;
    logic [2:0]     owner, owner_n;
    logic [N-1:0]   grant_n, done_n;
    logic [2:0]     error_id_n;
    logic [7:0]     count_n;

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_sh;
    logic [N-1:0]   req_rot;
    logic           pick_found;
    logic [2:0]     pick_rel;
    logic [3:0]     pick_sum;
    logic [2:0]     pick_idx;
    logic [N-1:0]   pick_onehot;

    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        return (idx == 3'(N - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Rotate requests so rr_ptr lands on bit 0; the lowest set bit is then the winner.
    assign req_dbl = {req, req};
    assign req_sh  = req_dbl >> rr_ptr;
    assign req_rot = req_sh[N-1:0];

    always_comb begin
        pick_found = 1'b0;
        pick_rel   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_found = 1'b1;
                pick_rel   = 3'(i);
            end
        end
    end

    assign pick_sum    = {1'b0, rr_ptr} + {1'b0, pick_rel};
    assign pick_idx    = (pick_sum >= 4'(N)) ? 3'(pick_sum - 4'(N)) : pick_sum[2:0];
    assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        rr_ptr_n   = rr_ptr;
        owner_n    = owner;
        grant_n    = grant;
        done_n     = '0;
        error_id_n = error_id;
        count_n    = service_count;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_n = S_GRANT;
                    owner_n = pick_idx;
                    grant_n = pick_onehot;
                    timer_n = '0;
                end
            end
            S_GRANT: begin
                timer_n = '0;
                state_n = S_SERVICE;
            end
            S_SERVICE: begin
                // Completion wins over a timeout landing on the same cycle.
                if (mant_terminado) begin
                    state_n  = S_DONE;
                    done_n   = grant;
                    count_n  = sat_inc(service_count);
                    rr_ptr_n = wrap_inc(owner);
                end else if (timer == TIMEOUT_LAST) begin
                    state_n    = S_ERROR;
                    error_id_n = owner;
                    grant_n    = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_DONE: begin
                grant_n = '0;
                timer_n = '0;
                state_n = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (timer == COOL_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_ERROR: begin
                if (clear_error) begin
                    rr_ptr_n = wrap_inc(error_id);
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            rr_ptr        <= 3'd0;
            owner         <= 3'd0;
            mant_on       <= 1'b0;
            grant         <= '0;
            done          <= '0;
            busy          <= 1'b0;
            error         <= 1'b0;
            error_id      <= 3'd0;
            service_count <= 8'd0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            rr_ptr        <= rr_ptr_n;
            owner         <= owner_n;
            mant_on       <= (state_n == S_SERVICE);
            grant         <= grant_n;
            done          <= done_n;
            busy          <= (state_n != S_IDLE);
            error         <= (state_n == S_ERROR);
            error_id      <= error_id_n;
            service_count <= count_n;
        end
    end

endmodule

// File: tb/tb_mantenimiento_arbiter.sv
// Directed bench for mantenimiento_arbiter: expected grants are queued as stimulus is
// applied and popped when the DUT shows a grant.
module tb_mantenimiento_arbiter;
    localparam int N   = 4;
    localparam int MAX = 20;
    localparam int CD  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic         mant_terminado;
    logic         clear_error;
    logic         mant_on;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic         error;
    logic [2:0]   error_id;
    logic [7:0]   service_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    int hi;
    int cd;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] last_exp;

    mantenimiento_arbiter #(.N(N), .MAX_CYCLES(MAX), .COOLDOWN_CYCLES(CD)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .mant_terminado (mant_terminado),
        .clear_error    (clear_error),
        .mant_on        (mant_on),
        .grant          (grant),
        .done           (done),
        .busy           (busy),
        .error          (error),
        .error_id       (error_id),
        .service_count  (service_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a grant; counts busy-but-ungranted cycles seen on the way.
    task automatic wait_grant(input string tag, output int cool);
        int n;
        n = 0;
        cool = 0;
        do begin
            tick();
            n++;
            if (grant == '0 && busy) cool++;
        end while (grant == '0 && n < 12);
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        else last_exp = '0;
        check(tag, grant, last_exp);
    endtask

    task automatic finish_cooldown(input string tag);
        repeat (CD) tick();
        check({tag, "_cd_busy"}, busy, 1);
        check({tag, "_cd_grant"}, grant, 0);
        tick();
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        exp_count = 0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req = 4'b1111;
        mant_terminado = 1'b1;
        clear_error = 1'b0;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_mant_on", mant_on, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_error_id", error_id, 0);
        check("rst_count", service_count, 0);

        // Release: grant one cycle later, mant_on one cycle after that.
        reset = 1'b1;
        mant_terminado = 1'b0;
        exp_q.push_back(4'b0001);
        wait_grant("rel_grant", cd);
        check("rel_grant_mant_off", mant_on, 0);
        tick();
        check("rel_mant_on", mant_on, 1);
        req = 4'b0000;
        mant_terminado = 1'b1;
        tick();
        mant_terminado = 1'b0;
        exp_count++;
        check("rel_done", done, last_exp);
        check("rel_count", service_count, exp_count);
        finish_cooldown("rel");

        // Single service with terminado five cycles after mant_on rises.
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("single_grant", cd);
        tick();
        hi = mant_on ? 1 : 0;
        repeat (5) begin
            tick();
            if (mant_on) hi++;
        end
        mant_terminado = 1'b1;
        tick();
        mant_terminado = 1'b0;
        req = 4'b0000;
        exp_count++;
        check("single_mant_cycles", hi, 6);
        check("single_mant_off", mant_on, 0);
        check("single_done", done, last_exp);
        check("single_count", service_count, exp_count);
        tick();
        check("single_done_pulse", done, 0);
        repeat (CD - 1) tick();
        check("single_cd_busy", busy, 1);
        tick();
        check("single_idle_busy", busy, 0);

        // Round-robin with all requests held.
        do_reset();
        req = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        for (int s = 0; s < 5; s++) begin
            wait_grant($sformatf("rr_grant%0d", s), cd);
            if (s > 0) check($sformatf("rr_cooldown%0d", s), cd, CD);
            repeat (3) tick();
            if (s == 4) req = 4'b0000;
            mant_terminado = 1'b1;
            tick();
            mant_terminado = 1'b0;
            exp_count++;
            check($sformatf("rr_done%0d", s), done, last_exp);
        end
        check("rr_count", service_count, exp_count);
        finish_cooldown("rr");

        // Timeout: terminado never comes.
        do_reset();
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant("to_grant", cd);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mant_on) hi++;
            else break;
        end
        check("to_mant_cycles", hi, MAX);
        check("to_error", error, 1);
        check("to_error_id", error_id, 1);
        check("to_grant_zero", grant, 0);
        check("to_count", service_count, exp_count);
        check("to_busy", busy, 1);
        tick();
        check("to_error_holds", error, 1);
        req = 4'b0011;
        clear_error = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        clear_error = 1'b0;
        check("clr_error", error, 0);
        check("clr_error_id_hold", error_id, 1);
        wait_grant("clr_grant_wrap", cd);

        // Boundary: terminado on the last allowed SERVICE cycle.
        tick();
        hi = mant_on ? 1 : 0;
        repeat (MAX - 1) begin
            tick();
            if (mant_on) hi++;
        end
        mant_terminado = 1'b1;
        tick();
        mant_terminado = 1'b0;
        req = 4'b0000;
        exp_count++;
        check("bnd_mant_cycles", hi, MAX);
        check("bnd_done", done, last_exp);
        check("bnd_no_error", error, 0);
        check("bnd_count", service_count, exp_count);
        finish_cooldown("bnd");

        // Reset on the 10th SERVICE cycle; rr_ptr was 1 before it.
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        wait_grant("mid_grant", cd);
        repeat (10) tick();
        check("mid_mant_on", mant_on, 1);
        reset = 1'b0;
        tick();
        check("mid_rst_mant_on", mant_on, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_count", service_count, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b1;
        exp_count = 0;
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        wait_grant("mid_rel_grant", cd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
